// File: rtl/ram_master_pkg.sv
// ram_master_pkg
// Shared definitions for the RAM burst master: default widths, the beat
// limit of one burst and the FSM state encodings. Every RAM master file
// imports this package so the encodings exist in exactly one place.
// No ports (package only).
package ram_master_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // A burst length field of ADDR_W bits gives at most 2**ADDR_W beats.
    localparam int MAX_BEATS = 16;

    // FSM encodings kept as plain constants so older tools can share them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // True for the states that are allowed to drive the RAM.
    function automatic logic is_mem_state(input logic [1:0] s);
        return (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/ram_master_addr_counter4.sv
// addr_counter4
// RAM address counter for the burst master: synchronous load of a burst
// start address, increment by one per beat, natural wrap from the top
// address back to 0.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears the count
//   load       load load_value this edge (takes priority over inc)
//   load_value burst start address
//   inc        advance the address by one this edge
//   value      current address
module addr_counter4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Wrap from all-ones to zero comes for free from the W-bit adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/ram_master.sv
// ram_master
// Burst controller in front of a single-port RAM with combinational read
// data. A request carries a start address and a length (beats minus one);
// write bursts stream wr_data into consecutive addresses, read bursts
// stream RAM words out through a one-entry registered output stage with
// valid/ready flow control. done pulses for one cycle per completed burst.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            burst request handshake
//   req_write, req_addr, req_len   burst direction, start address, beats-1
//   wr_valid/wr_ready, wr_data     write beat stream
//   rd_valid/rd_ready, rd_data     read beat stream
//   done                           one-cycle burst-complete pulse
//   mem_addr, mem_write_en,
//   mem_read_en, mem_data_in       RAM command side
//   mem_data_out                   RAM read data (valid while mem_read_en)
module ram_master
    import ram_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] count;
    logic              done_q;

    logic in_idle;
    logic in_write;
    logic in_read;
    logic accept_req;
    logic write_beat;
    logic read_issue;
    logic last_beat;

    // Every RAM-facing strobe is masked by rst so a reset cycle can never
    // leak a write or read from a burst that is being aborted.
    assign in_idle    = !rst && (state == ST_IDLE);
    assign in_write   = !rst && (state == ST_WRITE);
    assign in_read    = !rst && (state == ST_READ);
    assign accept_req = in_idle && req_valid;
    assign write_beat = in_write && wr_valid;
    // A new word may be fetched only when the output stage is empty or is
    // being emptied on this same edge.
    assign read_issue = in_read && (!rd_valid || rd_ready);
    assign last_beat  = (count == '0);

    assign req_ready    = in_idle;
    assign wr_ready     = in_write;
    assign mem_write_en = write_beat;
    assign mem_read_en  = read_issue;
    assign mem_addr     = (!rst && is_mem_state(state)) ? addr : '0;
    assign mem_data_in  = in_write ? wr_data : '0;
    assign done         = done_q && !rst;

    addr_counter4 #(
        .W(ADDR_W)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_req),
        .load_value(req_addr),
        .inc       (write_beat || read_issue),
        .value     (addr)
    );

    // Burst sequencing: the beat counter runs down to zero and the FSM
    // leaves the data state on the beat issued with count zero. Read bursts
    // pass through DRAIN so done waits until the last word is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        count <= req_len;
                        state <= req_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_valid) begin
                        if (last_beat) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // Acceptance of the held word is implied by read_issue
                    // whenever rd_valid is set, so capture covers both.
                    if (read_issue) begin
                        rd_data  <= mem_data_out;
                        rd_valid <= 1'b1;
                        if (last_beat) begin
                            state <= ST_DRAIN;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        state    <= ST_IDLE;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master
// Self-checking bench for ram_master. A behavioural RAM sits on the memory
// port; a separate reference image of the RAM is updated from burst
// arithmetic (start address plus beat index, modulo 16) and compared with
// the RAM at the end. Directed vectors come from a table, followed by
// reset-abort and randomized bursts.
module tb_ram_master;
    import ram_master_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    logic [DW-1:0] ram     [MAX_BEATS];
    logic [DW-1:0] ref_ram [MAX_BEATS];
    logic          ram_clear;

    int compared      = 0;
    int mismatched    = 0;
    int write_count   = 0;
    int overlap_count = 0;

    typedef struct packed {
        logic          write;
        logic [3:0]    addr;
        logic [3:0]    len;
        logic [1:0]    mode;
        logic [3:0][7:0] data;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    ram_master #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_write_en(mem_write_en),
        .mem_read_en (mem_read_en),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Behavioural RAM: combinational read, write on the rising edge.
    assign mem_data_out = mem_read_en ? ram[mem_addr] : '0;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MAX_BEATS; i++) ram[i] <= '0;
        end else if (mem_write_en) begin
            ram[mem_addr] <= mem_data_in;
        end
    end

    // Counts RAM writes and any cycle with both strobes high.
    always @(posedge clk) begin
        if (mem_write_en) write_count <= write_count + 1;
        if (mem_write_en && mem_read_en) overlap_count <= overlap_count + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [3:0] a,
                                 input logic [3:0] l);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
    endtask

    function automatic vec_t mkVec(input logic w, input logic [3:0] a,
                                   input logic [3:0] l, input logic [1:0] m,
                                   input logic [7:0] d0, input logic [7:0] d1,
                                   input logic [7:0] d2, input logic [7:0] d3);
        vec_t v;
        v.write   = w;
        v.addr    = a;
        v.len     = l;
        v.mode    = m;
        v.data[0] = d0;
        v.data[1] = d1;
        v.data[2] = d2;
        v.data[3] = d3;
        return v;
    endfunction

    // Write burst. mode 0: wr_valid continuous; 1: wr_valid pattern
    // 1,0,0,1,1 then continuous; 2: random wr_valid plus stray requests.
    task automatic writeBurst(input logic [3:0] a, input logic [3:0] l,
                              input logic [7:0] d [16], input int mode);
        int beat, c, nbeats, writes0, eaddr;
        logic wv;
        logic [4:0] pat;
        pat    = 5'b11001;
        nbeats = int'(l) + 1;
        beat   = 0;
        c      = 0;
        @(negedge clk);
        applyStimulus(1'b1, a, l);
        #1;
        checkOutput("wr_req_ready", req_ready, 1);
        writes0 = write_count;
        @(negedge clk);
        req_valid = 1'b0;
        while (beat < nbeats && c < 300) begin
            if (mode == 1) wv = (c < 5) ? pat[c] : 1'b1;
            else if (mode == 2) wv = 1'($urandom_range(0, 1));
            else wv = 1'b1;
            wr_valid = wv;
            wr_data  = d[beat];
            if (mode == 2) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'b0;
            end
            #1;
            checkOutput("wr_ready", wr_ready, 1);
            checkOutput("wr_done_mid", done, 0);
            checkOutput("wr_write_en", mem_write_en, wv);
            checkOutput("wr_no_read", mem_read_en, 0);
            if (wv) begin
                eaddr = (int'(a) + beat) % 16;
                checkOutput("wr_addr", mem_addr, eaddr);
                checkOutput("wr_data", mem_data_in, d[beat]);
                ref_ram[eaddr] = d[beat];
                beat++;
            end
            c++;
            @(negedge clk);
        end
        if (beat < nbeats) checkOutput("wr_timeout", beat, nbeats);
        wr_valid  = 1'b0;
        wr_data   = '0;
        req_valid = 1'b0;
        #1;
        checkOutput("wr_done", done, 1);
        checkOutput("wr_ready_after", wr_ready, 0);
        checkOutput("wr_count", write_count - writes0, nbeats);
        @(negedge clk);
        #1;
        checkOutput("wr_done_pulse", done, 0);
        checkOutput("wr_back_idle", req_ready, 1);
    endtask

    // Read burst. mode 0: rd_ready high; 1: rd_ready low for 3 cycles once
    // the first word is offered; 2: random rd_ready.
    task automatic readBurst(input logic [3:0] a, input logic [3:0] l,
                             input logic [7:0] exp [16], input int mode);
        int issued, received, c, stall_left, nbeats;
        logic exp_valid, exp_ren;
        nbeats     = int'(l) + 1;
        issued     = 0;
        received   = 0;
        c          = 0;
        stall_left = 3;
        @(negedge clk);
        applyStimulus(1'b0, a, l);
        #1;
        checkOutput("rd_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        while (received < nbeats && c < 300) begin
            exp_valid = (issued > received);
            if (mode == 1 && exp_valid && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
            end else if (mode == 2) begin
                rd_ready = 1'($urandom_range(0, 1));
            end else begin
                rd_ready = 1'b1;
            end
            exp_ren = (issued < nbeats) && (!exp_valid || rd_ready);
            #1;
            checkOutput("rd_valid", rd_valid, exp_valid);
            checkOutput("rd_read_en", mem_read_en, exp_ren);
            checkOutput("rd_no_write", mem_write_en, 0);
            checkOutput("rd_done_mid", done, 0);
            if (exp_ren) checkOutput("rd_addr", mem_addr, (int'(a) + issued) % 16);
            if (exp_valid) checkOutput("rd_data", rd_data, exp[received]);
            if (exp_valid && rd_ready) received++;
            if (exp_ren) issued++;
            c++;
            @(negedge clk);
        end
        if (received < nbeats) checkOutput("rd_timeout", received, nbeats);
        rd_ready = 1'b0;
        #1;
        checkOutput("rd_done", done, 1);
        checkOutput("rd_valid_after", rd_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("rd_done_pulse", done, 0);
        checkOutput("rd_back_idle", req_ready, 1);
    endtask

    initial begin
        logic [7:0] d [16];
        vec_t v;
        logic [3:0] ra, rl;

        rst       = 1'b1;
        ram_clear = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        for (int i = 0; i < MAX_BEATS; i++) ref_ram[i] = '0;

        vecs[0] = mkVec(1'b1, 4'd3,  4'd2, 2'd0, 8'hA1, 8'hB2, 8'hC3, 8'h00);
        vecs[1] = mkVec(1'b0, 4'd3,  4'd2, 2'd0, 8'hA1, 8'hB2, 8'hC3, 8'h00);
        vecs[2] = mkVec(1'b1, 4'd14, 4'd3, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44);
        vecs[3] = mkVec(1'b0, 4'd14, 4'd3, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44);
        vecs[4] = mkVec(1'b0, 4'd15, 4'd1, 2'd2, 8'h22, 8'h33, 8'h00, 8'h00);
        vecs[5] = mkVec(1'b0, 4'd5,  4'd0, 2'd0, 8'hC3, 8'h00, 8'h00, 8'h00);
        vecs[6] = mkVec(1'b1, 4'd8,  4'd2, 2'd1, 8'h5A, 8'h6B, 8'h7C, 8'h00);
        vecs[7] = mkVec(1'b0, 4'd8,  4'd2, 2'd0, 8'h5A, 8'h6B, 8'h7C, 8'h00);

        // Reset: everything quiet while rst is held, even with requests.
        @(negedge clk);
        req_valid = 1'b1;
        wr_valid  = 1'b1;
        #1;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_write_en", mem_write_en, 0);
        checkOutput("rst_read_en", mem_read_en, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        #1;
        checkOutput("rst_rd_valid", rd_valid, 0);
        @(negedge clk);
        rst       = 1'b0;
        ram_clear = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("post_rst_req_ready", req_ready, 1);
        checkOutput("post_rst_rd_data", rd_data, 0);
        checkOutput("idle_ignores_wr", mem_write_en, 0);
        checkOutput("idle_wr_ready", wr_ready, 0);
        checkOutput("idle_mem_addr", mem_addr, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checkOutput("idle_done", done, 0);

        $display("[TB] directed vector table");
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            for (int k = 0; k < 16; k++) d[k] = (k < 4) ? v.data[k] : 8'h00;
            if (v.write) writeBurst(v.addr, v.len, d, int'(v.mode));
            else         readBurst(v.addr, v.len, d, int'(v.mode));
        end

        // Write burst of 6 beats at 9 aborted by reset after the 2nd beat.
        $display("[TB] reset abort during write burst");
        @(negedge clk);
        applyStimulus(1'b1, 4'd9, 4'd5);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hE0 + 8'(k);
            #1;
            checkOutput("abort_write_en", mem_write_en, 1);
            ref_ram[9 + k] = 8'hE0 + 8'(k);
            @(negedge clk);
        end
        rst      = 1'b1;
        wr_data  = 8'hEE;
        #1;
        checkOutput("abort_rst_write_en", mem_write_en, 0);
        checkOutput("abort_rst_wr_ready", wr_ready, 0);
        checkOutput("abort_rst_req_ready", req_ready, 0);
        checkOutput("abort_rst_read_en", mem_read_en, 0);
        checkOutput("abort_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_idle", req_ready, 1);
        checkOutput("abort_wr_ready", wr_ready, 0);
        checkOutput("abort_write_en", mem_write_en, 0);
        checkOutput("abort_mem_addr", mem_addr, 0);
        checkOutput("abort_data_in", mem_data_in, 0);
        checkOutput("abort_rd_valid", rd_valid, 0);
        checkOutput("abort_rd_data", rd_data, 0);
        checkOutput("abort_done", done, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checkOutput("abort_no_done", done, 0);

        $display("[TB] randomized bursts");
        for (int n = 0; n < 24; n++) begin
            ra = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
                writeBurst(ra, rl, d, 2);
            end else begin
                for (int k = 0; k < 16; k++) d[k] = ref_ram[(int'(ra) + k) % 16];
                readBurst(ra, rl, d, 2);
            end
        end

        for (int i = 0; i < MAX_BEATS; i++) checkOutput("ram_image", ram[i], ref_ram[i]);
        checkOutput("strobe_overlap", overlap_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
